// File: rtl/inst_encode_issue.sv
// Packs {RL,RR,RD,Op} tuples into 17-bit instruction words, buffers them in a FIFO and issues in order.
// Optional RAW hazard hold on recently issued destinations: define HAZARD_STALL_EN.
module inst_encode_issue #(
  parameter int DEPTH   = 4,
  parameter int HAZ_WIN = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rl,
  input  logic [4:0]               in_rr,
  input  logic [4:0]               in_rd,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [16:0]              Inst,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              issued_cnt,
  output logic                     hazard_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [15:0]   issued_reg;
  logic [16:0]   head;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty      = (count_reg == '0);
  assign head       = mem[rd_ptr_reg];
  assign in_ready   = (count_reg != CW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign Inst       = empty ? 17'd0 : head;
  assign out_valid  = ~empty & ~hazard_stall;
  assign fifo_count = count_reg;
  assign issued_cnt = issued_reg;

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_rl, in_rr, in_rd, in_op};
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      issued_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        issued_reg <= issued_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef HAZARD_STALL_EN
  logic [HAZ_WIN-1:0] sb_valid_reg;
  logic [4:0]         sb_rd_reg [HAZ_WIN];
  logic [HAZ_WIN-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < HAZ_WIN; gi++) begin : g_sb
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_valid_reg[gi] <= 1'b0;
            sb_rd_reg[gi]    <= '0;
          end else begin
            sb_valid_reg[gi] <= pop;
            sb_rd_reg[gi]    <= head[6:2];
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sb_valid_reg[gi] <= 1'b0;
            sb_rd_reg[gi]    <= '0;
          end else begin
            sb_valid_reg[gi] <= sb_valid_reg[gi-1];
            sb_rd_reg[gi]    <= sb_rd_reg[gi-1];
          end
        end
      end
      assign hit[gi] = sb_valid_reg[gi] &
                       ((sb_rd_reg[gi] == head[16:12]) | (sb_rd_reg[gi] == head[11:7]));
    end
  endgenerate

  assign hazard_stall = ~empty & (|hit);
`else
  assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encode_issue.sv
// Randomized and directed bench for inst_encode_issue against a queue-based reference model.
// Follows HAZARD_STALL_EN the same way as the design build.
module tb_inst_encode_issue;
  localparam int DEPTH   = 4;
  localparam int HAZ_WIN = 3;
`ifdef HAZARD_STALL_EN
  localparam bit HAZ_ON = 1'b1;
`else
  localparam bit HAZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rl, in_rr, in_rd;
  logic [1:0]  in_op;
  logic        out_valid, out_ready;
  logic [16:0] Inst;
  logic [2:0]  fifo_count;
  logic [15:0] issued_cnt;
  logic        hazard_stall;

  inst_encode_issue #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rl(in_rl), .in_rr(in_rr), .in_rd(in_rd), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .Inst(Inst),
    .fifo_count(fifo_count), .issued_cnt(issued_cnt), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: pending words in order, issue counter, last issue cycle per register.
  logic [16:0] q[$];
  logic [15:0] m_issued;
  int          now;
  int          pop_cyc [32];
  bit          did_push, did_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] pack(input int rl, input int rr, input int rd, input int op);
    return {5'(rl), 5'(rr), 5'(rd), 2'(op)};
  endfunction

  function automatic bit model_stall();
    int rl, rr;
    if (!HAZ_ON || q.size() == 0) return 1'b0;
    rl = int'(q[0][16:12]);
    rr = int'(q[0][11:7]);
    return (now - pop_cyc[rl] <= HAZ_WIN) || (now - pop_cyc[rr] <= HAZ_WIN);
  endfunction

  task automatic model_reset();
    q.delete();
    m_issued = '0;
    for (int r = 0; r < 32; r++) pop_cyc[r] = -1000;
  endtask

  // One clock cycle: drive, check every output at the falling edge, advance the model at the edge.
  task automatic cyc(input bit v, input logic [16:0] w, input bit ordy);
    bit st, ov;
    in_valid = v;
    {in_rl, in_rr, in_rd, in_op} = w;
    out_ready = ordy;
    @(negedge clk);
    st = model_stall();
    ov = (q.size() != 0) && !st;
    check("in_ready", in_ready, q.size() != DEPTH);
    check("out_valid", out_valid, ov);
    check("hazard_stall", hazard_stall, st);
    check("fifo_count", fifo_count, q.size());
    check("issued_cnt", issued_cnt, m_issued);
    check("Inst", Inst, (q.size() != 0) ? q[0] : 17'd0);
    did_push = v && (q.size() != DEPTH);
    did_pop  = ov && ordy;
    @(posedge clk);
    if (did_pop) begin
      $display("[TB] issue %05h (cycle %0d)", q[0], now);
      pop_cyc[int'(q[0][6:2])] = now;
      void'(q.pop_front());
      m_issued++;
    end
    if (did_push) q.push_back(w);
    now++;
    #1;
  endtask

  initial begin
    logic [16:0] words [4];
    logic [16:0] w;
    int sent, stalls, k;
    logic [15:0] base;
    bit pending;

    now = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 0; in_rl = 0; in_rr = 0; in_rd = 0; in_op = 0; out_ready = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_inst", Inst, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pack
    cyc(1, pack(3, 5, 7, 2), 1);
    check("pack_valid", out_valid, 1);
    check("pack_inst", Inst, 17'h0329E);
    cyc(0, '0, 1);
    check("pack_issued", issued_cnt, 1);

    // Fill to full, refuse fifth, then drain in order
    for (int i = 0; i < 4; i++) begin
      words[i] = pack(i, i + 1, 20 + i, i);
      cyc(1, words[i], 0);
    end
    check("fill_count", fifo_count, 4);
    check("fill_in_ready", in_ready, 0);
    cyc(1, pack(1, 1, 30, 3), 0);
    check("fifth_dropped_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", Inst, words[i]);
      cyc(0, '0, 1);
    end

    // Full with push and pop requested together
    for (int i = 0; i < 4; i++) cyc(1, pack(i, i, 24 + i, 0), 0);
    cyc(1, pack(2, 3, 28, 1), 1);
    check("full_pop_only", fifo_count, 3);
    cyc(1, pack(2, 3, 29, 1), 1);
    check("push_pop_same", fifo_count, 3);

    // Reset mid-stream with 3 held
    cyc(0, '0, 0);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_issued", issued_cnt, 0);
    model_reset();
    @(posedge clk); now++; #1;
    rst_n = 1'b1;
    cyc(1, pack(6, 7, 8, 1), 1);
    check("postrst_inst", Inst, pack(6, 7, 8, 1));
    cyc(0, '0, 1);
    check("postrst_issued", issued_cnt, 1);

    // RAW hazard: producer writes r9, consumer reads r9
    cyc(1, pack(1, 2, 9, 0), 1);
    cyc(1, pack(9, 3, 4, 1), 1);
    check("haz_flag", hazard_stall, HAZ_ON);
    stalls = 0;
    for (k = 0; k < 20; k++) begin
      if (out_valid) break;
      stalls++;
      cyc(0, '0, 1);
    end
    check("haz_stall_cycles", stalls, HAZ_ON ? HAZ_WIN : 0);
    cyc(0, '0, 1);
    check("haz_drained", fifo_count, 0);

    // Random backpressure over 50 tuples
    base = issued_cnt;
    sent = 0;
    pending = 0;
    w = '0;
    for (k = 0; k < 3000; k++) begin
      if (sent == 50 && q.size() == 0) break;
      if (!pending && sent < 50) begin
        w = 17'($urandom);
        pending = 1;
      end
      cyc(pending && ($urandom_range(0, 3) != 0), w, $urandom_range(0, 1) == 1);
      if (did_push) begin
        sent++;
        pending = 0;
      end
    end
    check("rand_terminated", (k < 3000), 1);
    check("rand_issued", issued_cnt - base, 50);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
